// File: rtl/time_event_scheduler.sv
// Free-running time counter with NSLOT absolute-deadline slots; expired slots are
// arbitrated lowest-index-first and dispatched one timestamped event per cycle.
module time_event_scheduler #(
    parameter int NSLOT = 4,
    parameter int TW    = 32,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             arm,
    input  logic [IDW-1:0]   arm_slot,
    input  logic [TW-1:0]    arm_time,
    input  logic             cancel,
    input  logic [IDW-1:0]   cancel_slot,
    input  logic             err_clr,
    output logic [TW-1:0]    now,
    output logic [NSLOT-1:0] armed,
    output logic [NSLOT-1:0] pending,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDW-1:0]   ev_slot,
    output logic [TW-1:0]    ev_due,
    output logic [TW-1:0]    ev_now,
    output logic             err_arm
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_PENDING = 2'd2
    } slot_state_e;

    logic [TW-1:0]    now_q, now_d;
    logic             ev_valid_q, ev_valid_d;
    logic [IDW-1:0]   ev_slot_q, ev_slot_d;
    logic [TW-1:0]    ev_due_q, ev_due_d;
    logic [TW-1:0]    ev_now_q, ev_now_d;
    logic             err_q, err_d;

    logic [TW-1:0]    deadline_vec [NSLOT];
    logic [NSLOT-1:0] cand;
    logic             disp_free;
    logic             sel_any;
    logic [IDW-1:0]   sel_idx;
    logic             dispatch;

    always_comb begin
        now_d = now_q;
        if (clr)
            now_d = '0;
        else if (en)
            now_d = now_q + TW'(1);
    end

    // A slot being cancelled this cycle is not eligible for dispatch.
    always_comb begin
        cand = pending;
        if (cancel)
            cand[cancel_slot] = 1'b0;
        sel_any = |cand;
        sel_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (cand[i])
                sel_idx = IDW'(i);
        end
    end

    assign disp_free = !ev_valid_q || ev_ready;
    assign dispatch  = disp_free && sel_any;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : slot_g
            slot_state_e   state_q, state_d;
            logic [TW-1:0] deadline_q, deadline_d;
            logic          hit_arm, hit_cancel;

            assign hit_arm    = arm && (arm_slot == IDW'(gi));
            assign hit_cancel = cancel && (cancel_slot == IDW'(gi));

            // Compare uses pre-edge state and deadline, so a same-cycle arm never fires.
            always_comb begin
                state_d    = state_q;
                deadline_d = deadline_q;
                if (hit_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (hit_arm) begin
                                state_d    = S_ARMED;
                                deadline_d = arm_time;
                            end
                        end
                        S_ARMED: begin
                            if (hit_arm)
                                deadline_d = arm_time;
                            else if (now_q == deadline_q)
                                state_d = S_PENDING;
                        end
                        S_PENDING: begin
                            if (dispatch && (sel_idx == IDW'(gi)))
                                state_d = S_IDLE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= S_IDLE;
                    deadline_q <= '0;
                end else begin
                    state_q    <= state_d;
                    deadline_q <= deadline_d;
                end
            end

            assign armed[gi]        = (state_q == S_ARMED);
            assign pending[gi]      = (state_q == S_PENDING);
            assign deadline_vec[gi] = deadline_q;
        end
    endgenerate

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_slot_d  = ev_slot_q;
        ev_due_d   = ev_due_q;
        ev_now_d   = ev_now_q;
        if (dispatch) begin
            ev_valid_d = 1'b1;
            ev_slot_d  = sel_idx;
            ev_due_d   = deadline_vec[sel_idx];
            ev_now_d   = now_q;
        end else if (disp_free) begin
            ev_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (arm && pending[arm_slot])
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_slot_q  <= '0;
            ev_due_q   <= '0;
            ev_now_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            now_q      <= now_d;
            ev_valid_q <= ev_valid_d;
            ev_slot_q  <= ev_slot_d;
            ev_due_q   <= ev_due_d;
            ev_now_q   <= ev_now_d;
            err_q      <= err_d;
        end
    end

    assign now      = now_q;
    assign ev_valid = ev_valid_q;
    assign ev_slot  = ev_slot_q;
    assign ev_due   = ev_due_q;
    assign ev_now   = ev_now_q;
    assign err_arm  = err_q;

endmodule
